// File: rtl/alarm_pkg.sv
// Shared constants for the alarm-time edit controller.
//   - Field widths and minute modulus.
//   - Edit state encoding (plain constants so legacy tools can read them).
//   - Optional build macro ALARM_EDIT_CANCEL_EN adds a cancel button; it is consumed in
//     alarm_edit_ctrl_if.sv and alarm_edit_ctrl.sv.
package alarm_pkg;

    localparam int unsigned HH_W    = 5;
    localparam int unsigned MM_W    = 6;
    localparam int unsigned MINUTES = 60;
    localparam int unsigned ST_W    = 2;

    localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] ST_EDIT_HH = 2'd1;
    localparam logic [ST_W-1:0] ST_EDIT_MM = 2'd2;
    localparam logic [ST_W-1:0] ST_COMMIT  = 2'd3;

    // True while the user is walking a field.
    function automatic logic is_edit(input logic [ST_W-1:0] st);
        return (st == ST_EDIT_HH) || (st == ST_EDIT_MM);
    endfunction

endpackage

// File: rtl/alarm_edit_ctrl_if.sv
// Button / countdown / alarm-time bundle for alarm_edit_ctrl.
//   master : button and countdown side (drives buttons and saved, reads everything else)
//   slave  : the controller
//   btn_cancel exists only when ALARM_EDIT_CANCEL_EN is defined.
interface alarm_edit_ctrl_if;
    import alarm_pkg::*;

    logic            btn_mode;
    logic            btn_inc;
    logic            saved;
`ifdef ALARM_EDIT_CANCEL_EN
    logic            btn_cancel;
`endif
    logic            count_en;
    logic            editing;
    logic            field_sel;
    logic [HH_W-1:0] edit_hh;
    logic [MM_W-1:0] edit_mm;
    logic [HH_W-1:0] alarm_hh;
    logic [MM_W-1:0] alarm_mm;
    logic            commit;

`ifdef ALARM_EDIT_CANCEL_EN
    modport master (output btn_mode, btn_inc, saved, btn_cancel,
                    input  count_en, editing, field_sel, edit_hh, edit_mm,
                           alarm_hh, alarm_mm, commit);
    modport slave  (input  btn_mode, btn_inc, saved, btn_cancel,
                    output count_en, editing, field_sel, edit_hh, edit_mm,
                           alarm_hh, alarm_mm, commit);
`else
    modport master (output btn_mode, btn_inc, saved,
                    input  count_en, editing, field_sel, edit_hh, edit_mm,
                           alarm_hh, alarm_mm, commit);
    modport slave  (input  btn_mode, btn_inc, saved,
                    output count_en, editing, field_sel, edit_hh, edit_mm,
                           alarm_hh, alarm_mm, commit);
`endif

endinterface

// File: rtl/alarm_edit_ctrl_rise_det.sv
// btn_rise_det: registers the previous button level and flags a rising edge.
//   clk_i    : clock
//   rst_n_i  : synchronous active-low reset (previous level forced low)
//   level_i  : debounced button level
//   rise_c_o : combinational one-cycle pulse, level_i & ~previous level
module btn_rise_det (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic level_i,
    output logic rise_c_o
);

    logic level_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) level_q <= 1'b0;
        else          level_q <= level_i;
    end

    assign rise_c_o = level_i & ~level_q;

endmodule

// File: rtl/alarm_edit_ctrl.sv
// alarm_edit_ctrl: walks the user through hours then minutes, keeps a working copy and
// commits it to the alarm registers when the five-second countdown reports saved or when
// mode is pressed on the minutes field.
//   clk_1Hz  : tick clock          rst_n : synchronous active-low reset
//   bus      : alarm_edit_ctrl_if.slave (buttons, countdown handshake, edit/alarm outputs)
// Build option: ALARM_EDIT_CANCEL_EN adds btn_cancel, which abandons an edit without commit.
module alarm_edit_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned HOURS    = 24,
    parameter int unsigned RESET_HH = 7,
    parameter int unsigned RESET_MM = 0
) (
    input  logic              clk_1Hz,
    input  logic              rst_n,
    alarm_edit_ctrl_if.slave  bus
);

    logic [ST_W-1:0] state_q,     state_d;
    logic [HH_W-1:0] edit_hh_q,   edit_hh_d;
    logic [MM_W-1:0] edit_mm_q,   edit_mm_d;
    logic [HH_W-1:0] alarm_hh_q,  alarm_hh_d;
    logic [MM_W-1:0] alarm_mm_q,  alarm_mm_d;
    logic            count_en_q,  count_en_d;
    logic            editing_q,   editing_d;
    logic            field_sel_q, field_sel_d;
    logic            commit_q,    commit_d;
    logic            mode_rise_c;
    logic            action_c;
    logic [HH_W-1:0] hh_inc_c;
    logic [MM_W-1:0] mm_inc_c;

    btn_rise_det u_mode_rise (
        .clk_i    (clk_1Hz),
        .rst_n_i  (rst_n),
        .level_i  (bus.btn_mode),
        .rise_c_o (mode_rise_c)
    );

    // Wrapping increments; no carry from minutes into hours.
    assign hh_inc_c = (edit_hh_q == HH_W'(HOURS - 1))   ? '0 : edit_hh_q + HH_W'(1);
    assign mm_inc_c = (edit_mm_q == MM_W'(MINUTES - 1)) ? '0 : edit_mm_q + MM_W'(1);

    // State register and all registered outputs.
    always_ff @(posedge clk_1Hz) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            edit_hh_q   <= HH_W'(RESET_HH);
            edit_mm_q   <= MM_W'(RESET_MM);
            alarm_hh_q  <= HH_W'(RESET_HH);
            alarm_mm_q  <= MM_W'(RESET_MM);
            count_en_q  <= 1'b0;
            editing_q   <= 1'b0;
            field_sel_q <= 1'b0;
            commit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            edit_hh_q   <= edit_hh_d;
            edit_mm_q   <= edit_mm_d;
            alarm_hh_q  <= alarm_hh_d;
            alarm_mm_q  <= alarm_mm_d;
            count_en_q  <= count_en_d;
            editing_q   <= editing_d;
            field_sel_q <= field_sel_d;
            commit_q    <= commit_d;
        end
    end

    // Next state; any user action holds the countdown off for one cycle to restart it.
    always_comb begin
        state_d    = state_q;
        edit_hh_d  = edit_hh_q;
        edit_mm_d  = edit_mm_q;
        alarm_hh_d = alarm_hh_q;
        alarm_mm_d = alarm_mm_q;
        commit_d   = 1'b0;
        action_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mode_rise_c) begin
                    state_d   = ST_EDIT_HH;
                    edit_hh_d = alarm_hh_q;
                    edit_mm_d = alarm_mm_q;
                    action_c  = 1'b1;
                end
            end
            ST_EDIT_HH: begin
                if (mode_rise_c) begin
                    state_d  = ST_EDIT_MM;
                    action_c = 1'b1;
                end else if (bus.btn_inc) begin
                    edit_hh_d = hh_inc_c;
                    action_c  = 1'b1;
                end else if (bus.saved && count_en_q) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_EDIT_MM: begin
                if (mode_rise_c) begin
                    state_d  = ST_COMMIT;
                    action_c = 1'b1;
                end else if (bus.btn_inc) begin
                    edit_mm_d = mm_inc_c;
                    action_c  = 1'b1;
                end else if (bus.saved && count_en_q) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                alarm_hh_d = edit_hh_q;
                alarm_mm_d = edit_mm_q;
                commit_d   = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef ALARM_EDIT_CANCEL_EN
        // Cancel overrides every other request while editing.
        if (bus.btn_cancel && is_edit(state_q)) begin
            state_d   = ST_IDLE;
            edit_hh_d = alarm_hh_q;
            edit_mm_d = alarm_mm_q;
        end
`endif

        editing_d   = is_edit(state_d);
        field_sel_d = (state_d == ST_EDIT_MM);
        count_en_d  = editing_d && !action_c;
    end

    assign bus.count_en  = count_en_q;
    assign bus.editing   = editing_q;
    assign bus.field_sel = field_sel_q;
    assign bus.edit_hh   = edit_hh_q;
    assign bus.edit_mm   = edit_mm_q;
    assign bus.alarm_hh  = alarm_hh_q;
    assign bus.alarm_mm  = alarm_mm_q;
    assign bus.commit    = commit_q;

endmodule

// File: tb/tb_alarm_edit_ctrl.sv
// Bench for alarm_edit_ctrl: directed scenarios plus random button traffic. A behavioural
// model predicts the outputs after every clock and queues them; a monitor compares each
// cycle. A five-second countdown emulation driven by the model supplies saved.
module tb_alarm_edit_ctrl;

    localparam int HOURS = 24;

    typedef struct {
        int cen, editing, fsel, ehh, emm, ahh, amm, commit;
    } exp_t;

    logic clk_1Hz = 1'b0;
    logic rst_n   = 1'b0;
    alarm_edit_ctrl_if bus ();

    alarm_edit_ctrl #(.HOURS(HOURS), .RESET_HH(7), .RESET_MM(0)) dut (
        .clk_1Hz (clk_1Hz),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: phase 0 idle, 1 hours, 2 minutes, 3 saving.
    int phase = 0, w_hh = 7, w_mm = 0, a_hh = 7, a_mm = 0, m_cen = 0, m_commit = 0;
    int prev_mode = 0, cd_cnt = 0;
    int rnd_saved_en = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, step model, queue prediction.
    task automatic cyc(input int mode, input int inc, input int cancel, input int rstn);
        int saved, rise, act;
        exp_t e;
        @(negedge clk_1Hz);
        saved = (m_cen == 1 && cd_cnt == 4) ? 1 : 0;
        if (rnd_saved_en != 0 && $urandom_range(9) == 0) saved = 1;
        rst_n       = rstn[0];
        bus.btn_mode = mode[0];
        bus.btn_inc  = inc[0];
        bus.saved    = saved[0];
`ifdef ALARM_EDIT_CANCEL_EN
        bus.btn_cancel = cancel[0];
`else
        if (cancel != 0) cancel = 0;
`endif
        // countdown emulation sees current count_en
        cd_cnt = (m_cen == 1) ? cd_cnt + 1 : 0;
        if (rstn == 0) begin
            phase = 0; w_hh = 7; w_mm = 0; a_hh = 7; a_mm = 0;
            m_cen = 0; m_commit = 0; prev_mode = 0;
        end else begin
            rise = (mode != 0 && prev_mode == 0) ? 1 : 0;
            prev_mode = mode;
            act = 0;
            m_commit = 0;
            if (phase == 0) begin
                if (rise != 0) begin phase = 1; w_hh = a_hh; w_mm = a_mm; act = 1; end
            end else if (phase == 3) begin
                a_hh = w_hh; a_mm = w_mm; m_commit = 1; phase = 0;
            end else if (cancel != 0) begin
                phase = 0; w_hh = a_hh; w_mm = a_mm;
            end else if (rise != 0) begin
                phase = phase + 1; act = 1;
            end else if (inc != 0) begin
                if (phase == 1) w_hh = (w_hh + 1) % HOURS;
                else            w_mm = (w_mm + 1) % 60;
                act = 1;
            end else if (saved != 0 && m_cen != 0) begin
                phase = 3;
            end
            m_cen = (phase == 1 || phase == 2) && act == 0;
        end
        e.cen = m_cen; e.editing = (phase == 1 || phase == 2); e.fsel = (phase == 2);
        e.ehh = w_hh; e.emm = w_mm; e.ahh = a_hh; e.amm = a_mm; e.commit = m_commit;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1);
    endtask

    // Monitor: every output is valid each cycle, compare after the edge settles.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_1Hz);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count_en",  int'(bus.count_en),  e.cen);
                chk("editing",   int'(bus.editing),   e.editing);
                chk("field_sel", int'(bus.field_sel), e.fsel);
                chk("edit_hh",   int'(bus.edit_hh),   e.ehh);
                chk("edit_mm",   int'(bus.edit_mm),   e.emm);
                chk("alarm_hh",  int'(bus.alarm_hh),  e.ahh);
                chk("alarm_mm",  int'(bus.alarm_mm),  e.amm);
                chk("commit",    int'(bus.commit),    e.commit);
            end
        end
    end

    initial begin
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.saved    = 1'b0;
`ifdef ALARM_EDIT_CANCEL_EN
        bus.btn_cancel = 1'b0;
`endif
        // reset two clocks
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        idle(2);
        // 10:02 edit committed by the countdown
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1);
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 2; i++) cyc(0, 1, 0, 1);
        idle(9);
        // wrap hours 23 -> 0 and minutes 59 -> 0
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 14; i++) cyc(0, 1, 0, 1);
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 58; i++) cyc(0, 1, 0, 1);
        cyc(1, 0, 0, 1);
        idle(3);
        // inc every three clocks keeps restarting the countdown
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin cyc(0, 1, 0, 1); idle(2); end
        idle(9);
        // mode and inc together, then reset mid-edit
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(1, 1, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(0, 0, 0, 0);
        idle(3);
`ifdef ALARM_EDIT_CANCEL_EN
        // edit to 08:15 then cancel
        cyc(1, 0, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 15; i++) cyc(0, 1, 0, 1);
        cyc(1, 1, 1, 1);
        idle(8);
`endif
        // random traffic
        rnd_saved_en = 1;
        for (int i = 0; i < 600; i++)
            cyc(($urandom_range(3) == 0) ? 1 : 0,
                ($urandom_range(9) < 3) ? 1 : 0,
                ($urandom_range(19) == 0) ? 1 : 0,
                ($urandom_range(199) == 0) ? 0 : 1);
        rnd_saved_en = 0;
        idle(10);
        @(negedge clk_1Hz);
        @(negedge clk_1Hz);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d expected 0 pending", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
